ltssm_substate_sequencer: RTL and testbench

Top-level LTSSM sequencer for the three training substate blocks: Detect (index 0), Polling (index 1) and Configuration (index 2). It enables exactly one substate at a time and advances on that substate's success/error pulses. It shares the single PHY TX AXI-Stream between the substates with frame-boundary-safe switching, and runs retry/backoff and a per-substate watchdog. It sits between the substate modules and the PHY TX ordered-set path.

---
 rtl/ltssm_substate_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_ltssm_substate_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltssm_substate_sequencer.sv
// LTSSM sequencer: enables Detect/Polling/Config in turn, with retry/backoff and a per-substate watchdog.
// TX mux has zero latency and ready passes straight from downstream; switching waits for an open frame to close.
module ltssm_substate_sequencer #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int          USER_WIDTH     = 8,
  parameter logic [31:0] SUB_TIMEOUT    = 32'h0400_0000,
  parameter int          BACKOFF_CYCLES = 1024,
  parameter int          MAX_RETRIES    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  output logic                    link_up_o,
  output logic                    link_fail_o,
  output logic [2:0]              ltssm_state_o,
  output logic [3:0]              retry_cnt_o,
  output logic [2:0]              sub_en_o,
  input  logic [2:0]              sub_success_i,
  input  logic [2:0]              sub_error_i,
  input  logic [3*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [3*KEEP_WIDTH-1:0] s_axis_tkeep_i,
  input  logic [2:0]              s_axis_tvalid_i,
  input  logic [2:0]              s_axis_tlast_i,
  input  logic [3*USER_WIDTH-1:0] s_axis_tuser_i,
  output logic [2:0]              s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep_o,
  output logic                    m_axis_tvalid_o,
  output logic                    m_axis_tlast_o,
  output logic [USER_WIDTH-1:0]   m_axis_tuser_o,
  input  logic                    m_axis_tready_i
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DETECT  = 3'd1,
    ST_POLLING = 3'd2,
    ST_CONFIG  = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_L0      = 3'd5,
    ST_BACKOFF = 3'd6,
    ST_FAIL    = 3'd7
  } state_t;

  localparam logic [31:0] WDOG_LAST = SUB_TIMEOUT - 32'd1;
  localparam logic [15:0] BOFF_LAST = 16'(BACKOFF_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  state_t      target_q, target_d;
  logic [1:0]  sel_q, sel_d;
  logic        frame_open_q, frame_open_d;
  logic [31:0] wdog_q, wdog_d;
  logic [15:0] boff_q, boff_d;
  logic [3:0]  retry_q, retry_d;
  logic [2:0]  sub_en_q, sub_en_d;
  logic        link_up_q, link_up_d;
  logic        link_fail_q, link_fail_d;

  logic        in_sub;
  logic        allow;
  logic        beat_fire;
  logic        sel_succ;
  logic        sel_err;
  logic        drain_done;
  state_t      drain_dest;
  logic [2:0]  dest_idx;
  logic [3:0]  retry_inc;

  function automatic state_t next_after(input state_t s);
    case (s)
      ST_DETECT:  return ST_POLLING;
      ST_POLLING: return ST_CONFIG;
      default:    return ST_L0;
    endcase
  endfunction

  assign in_sub     = (state_q == ST_DETECT) || (state_q == ST_POLLING) || (state_q == ST_CONFIG);
  // An open frame keeps the path alive through DRAIN so it is never truncated; no new frame may start there.
  assign allow      = in_sub || ((state_q == ST_DRAIN) && frame_open_q);
  assign sel_succ   = sub_success_i[sel_q];
  assign sel_err    = sub_error_i[sel_q];
  assign drain_done = !frame_open_q && !sel_succ && !sel_err;
  assign drain_dest = start_i ? target_q : ST_IDLE;
  assign dest_idx   = 3'(drain_dest) - 3'd1;
  assign retry_inc  = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

  always_comb begin
    m_axis_tdata_o  = '0;
    m_axis_tkeep_o  = '0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tlast_o  = 1'b0;
    m_axis_tuser_o  = '0;
    s_axis_tready_o = '0;
    if (allow) begin
      m_axis_tdata_o         = s_axis_tdata_i[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tkeep_o         = s_axis_tkeep_i[int'(sel_q)*KEEP_WIDTH +: KEEP_WIDTH];
      m_axis_tvalid_o        = s_axis_tvalid_i[sel_q];
      m_axis_tlast_o         = s_axis_tlast_i[sel_q];
      m_axis_tuser_o         = s_axis_tuser_i[int'(sel_q)*USER_WIDTH +: USER_WIDTH];
      s_axis_tready_o[sel_q] = m_axis_tready_i;
    end
  end

  assign beat_fire = m_axis_tvalid_o && m_axis_tready_i;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    sel_d        = sel_q;
    wdog_d       = wdog_q;
    boff_d       = boff_q;
    retry_d      = retry_q;
    frame_open_d = beat_fire ? !m_axis_tlast_o : frame_open_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_DETECT;
          sel_d   = 2'd0;
          wdog_d  = '0;
        end
      end
      ST_DETECT, ST_POLLING, ST_CONFIG: begin
        if (wdog_q != '1) wdog_d = wdog_q + 32'd1;
        // Abort beats error, and error beats success.
        if (!start_i) begin
          state_d  = ST_DRAIN;
          target_d = ST_IDLE;
        end else if (sel_err || (wdog_q >= WDOG_LAST)) begin
          state_d  = ST_DRAIN;
          target_d = ST_BACKOFF;
        end else if (sel_succ) begin
          state_d  = ST_DRAIN;
          target_d = next_after(state_q);
        end
      end
      ST_DRAIN: begin
        if (!start_i) target_d = ST_IDLE;
        if (drain_done) begin
          state_d = drain_dest;
          if ((drain_dest == ST_DETECT) || (drain_dest == ST_POLLING) || (drain_dest == ST_CONFIG)) begin
            sel_d  = dest_idx[1:0];
            wdog_d = '0;
          end
          if (drain_dest == ST_BACKOFF) boff_d = '0;
        end
      end
      ST_L0: begin
        if (!start_i) state_d = ST_IDLE;
      end
      ST_BACKOFF: begin
        if (!start_i) begin
          state_d = ST_IDLE;
        end else if (boff_q >= BOFF_LAST) begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_DETECT;
            sel_d   = 2'd0;
            wdog_d  = '0;
          end
        end else begin
          boff_d = boff_q + 16'd1;
        end
      end
      default: begin
        if (!start_i) state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_IDLE) retry_d = '0;

    sub_en_d = '0;
    case (state_d)
      ST_DETECT:  sub_en_d = 3'b001;
      ST_POLLING: sub_en_d = 3'b010;
      ST_CONFIG:  sub_en_d = 3'b100;
      default:    sub_en_d = 3'b000;
    endcase
    link_up_d   = (state_d == ST_L0);
    link_fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      target_q     <= ST_IDLE;
      sel_q        <= 2'd0;
      frame_open_q <= 1'b0;
      wdog_q       <= '0;
      boff_q       <= '0;
      retry_q      <= '0;
      sub_en_q     <= '0;
      link_up_q    <= 1'b0;
      link_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      sel_q        <= sel_d;
      frame_open_q <= frame_open_d;
      wdog_q       <= wdog_d;
      boff_q       <= boff_d;
      retry_q      <= retry_d;
      sub_en_q     <= sub_en_d;
      link_up_q    <= link_up_d;
      link_fail_q  <= link_fail_d;
    end
  end

  assign ltssm_state_o = state_q;
  assign sub_en_o      = sub_en_q;
  assign link_up_o     = link_up_q;
  assign link_fail_o   = link_fail_q;
  assign retry_cnt_o   = retry_q;

endmodule

// File: tb/tb_ltssm_substate_sequencer.sv
// Directed bench for ltssm_substate_sequencer with small timeout/backoff values so every path is reachable quickly.
module tb_ltssm_substate_sequencer;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    succ = '0, err = '0, s_valid = '0, s_last = '0;
  logic [3*DW-1:0] s_data = '0;
  logic [3*KW-1:0] s_keep = '0;
  logic [3*UW-1:0] s_user = '0;
  logic          m_ready = 1'b0;

  logic          link_up, link_fail, m_valid, m_last;
  logic [2:0]    st, sub_en, s_rdy;
  logic [3:0]    retry;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic [UW-1:0] m_user;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ltssm_substate_sequencer #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .SUB_TIMEOUT(32'd100), .BACKOFF_CYCLES(16), .MAX_RETRIES(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .link_up_o(link_up), .link_fail_o(link_fail), .ltssm_state_o(st), .retry_cnt_o(retry),
    .sub_en_o(sub_en), .sub_success_i(succ), .sub_error_i(err),
    .s_axis_tdata_i(s_data), .s_axis_tkeep_i(s_keep), .s_axis_tvalid_i(s_valid),
    .s_axis_tlast_i(s_last), .s_axis_tuser_i(s_user), .s_axis_tready_o(s_rdy),
    .m_axis_tdata_o(m_data), .m_axis_tkeep_o(m_keep), .m_axis_tvalid_o(m_valid),
    .m_axis_tlast_o(m_last), .m_axis_tuser_o(m_user), .m_axis_tready_i(m_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (st == s) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = (st == s);
  endtask

  task automatic go_to_sub(input int k);
    start = 1'b1;
    tick();
    for (int j = 0; j < k; j++) begin
      succ[j] = 1'b1;
      tick();
      succ[j] = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st); end
    checks++; if (sub_en !== 3'b000) begin errors++; $display("FAIL reset_sub_en: got %b expected 000", sub_en); end
    checks++; if (link_up !== 1'b0 || link_fail !== 1'b0) begin errors++; $display("FAIL reset_link: got up=%b fail=%b expected 0/0", link_up, link_fail); end
    checks++; if (retry !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", retry); end
    checks++; if (m_valid !== 1'b0 || s_rdy !== 3'b000) begin errors++; $display("FAIL reset_stream: got valid=%b rdy=%b expected 0/000", m_valid, s_rdy); end
    rst_n = 1'b1;
    tick();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", st); end
  endtask

  task automatic test_happy_path();
    logic [2:0] exp_en;
    start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_en = 3'b001 << k;
      checks++; if (st !== 3'(k + 1)) begin errors++; $display("FAIL happy_state: got %0d expected %0d", st, k + 1); end
      for (int c = 0; c < 20; c++) begin
        checks++; if (sub_en !== exp_en) begin errors++; $display("FAIL happy_sub_en: got %b expected %b", sub_en, exp_en); end
        tick();
      end
      succ[k] = 1'b1;
      tick();
      checks++; if (st !== 3'd4) begin errors++; $display("FAIL happy_drain: got %0d expected 4", st); end
      checks++; if (sub_en !== 3'b000) begin errors++; $display("FAIL happy_drain_en: got %b expected 000", sub_en); end
      succ[k] = 1'b0;
      tick();
    end
    checks++; if (st !== 3'd5) begin errors++; $display("FAIL happy_l0: got %0d expected 5", st); end
    checks++; if (link_up !== 1'b1 || link_fail !== 1'b0) begin errors++; $display("FAIL happy_link_up: got up=%b fail=%b expected 1/0", link_up, link_fail); end
    checks++; if (retry !== 4'd0) begin errors++; $display("FAIL happy_retry: got %0d expected 0", retry); end
    start = 1'b0;
    tick();
    checks++; if (st !== 3'd0 || link_up !== 1'b0) begin errors++; $display("FAIL happy_drop: got state=%0d up=%b expected 0/0", st, link_up); end
  endtask

  task automatic test_ignore_other();
    start = 1'b1;
    tick();
    succ = 3'b110;
    err  = 3'b110;
    tick();
    checks++; if (st !== 3'd1) begin errors++; $display("FAIL ignore_other: got %0d expected 1", st); end
    succ = '0;
    err  = '0;
    start = 1'b0;
    tick();
    checks++; if (st !== 3'd4) begin errors++; $display("FAIL abort_drain: got %0d expected 4", st); end
    tick();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL abort_idle: got %0d expected 0", st); end
  endtask

  task automatic test_mid_frame();
    int beat, acc, cyc;
    logic [31:0] exp_d;
    logic [2:0] exp_st;
    bit ok;
    go_to_sub(1);
    checks++; if (st !== 3'd2) begin errors++; $display("FAIL mid_polling: got %0d expected 2", st); end
    s_keep[KW +: KW] = 4'hF;
    beat = 1; acc = 0; cyc = 0;
    while (acc < 2 && cyc < 20) begin
      exp_d = 32'hA000 + 32'(beat);
      s_valid[1] = 1'b1; s_data[DW +: DW] = exp_d; s_last[1] = (beat == 4); s_user[UW +: UW] = 8'(beat);
      m_ready = (cyc % 2) == 1;
      #1;
      checks++; if (m_valid !== 1'b1 || m_data !== exp_d || m_keep !== 4'hF || s_rdy !== {1'b0, m_ready, 1'b0})
        begin errors++; $display("FAIL mid_pre_beat: got v=%b d=%h k=%h rdy=%b expected 1/%h/f/0%b0", m_valid, m_data, m_keep, s_rdy, exp_d, m_ready); end
      if (m_ready) begin acc++; beat++; end
      tick(); cyc++;
    end
    succ[1] = 1'b1;
    for (int i = 0; beat <= 4 && i < 20; i++) begin
      exp_d = 32'hA000 + 32'(beat);
      exp_st = (i == 0) ? 3'd2 : 3'd4;
      s_data[DW +: DW] = exp_d; s_last[1] = (beat == 4); s_user[UW +: UW] = 8'(beat);
      m_ready = (cyc % 2) == 1;
      #1;
      checks++; if (st !== exp_st) begin errors++; $display("FAIL mid_state: got %0d expected %0d", st, exp_st); end
      if (i > 0) begin
        checks++; if (sub_en !== 3'b000) begin errors++; $display("FAIL mid_drain_en: got %b expected 000", sub_en); end
      end
      checks++; if (m_valid !== 1'b1 || m_data !== exp_d || m_last !== (beat == 4) || m_user !== 8'(beat) || s_rdy !== {1'b0, m_ready, 1'b0})
        begin errors++; $display("FAIL mid_tail_beat: got v=%b d=%h l=%b u=%h rdy=%b expected beat %0d", m_valid, m_data, m_last, m_user, s_rdy, beat); end
      if (m_ready) beat++;
      tick(); cyc++;
    end
    checks++; if (beat != 5) begin errors++; $display("FAIL mid_beats_done: got %0d beats expected 4", beat - 1); end
    s_data[DW +: DW] = 32'hA001; s_last[1] = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (st !== 3'd4 || m_valid !== 1'b0 || s_rdy !== 3'b000)
        begin errors++; $display("FAIL mid_no_new_frame: got state=%0d v=%b rdy=%b expected 4/0/000", st, m_valid, s_rdy); end
      tick();
    end
    succ[1] = 1'b0;
    tick();
    checks++; if (st !== 3'd3 || sub_en !== 3'b100) begin errors++; $display("FAIL mid_config: got state=%0d en=%b expected 3/100", st, sub_en); end
    checks++; if (m_valid !== 1'b0 || s_rdy !== 3'b100) begin errors++; $display("FAIL mid_config_sel: got v=%b rdy=%b expected 0/100", m_valid, s_rdy); end
    s_valid = '0; m_ready = 1'b0; start = 1'b0;
    wait_state(3'd0, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_return_idle: got state=%0d expected 0", st); end
  endtask

  task automatic test_retry_fail();
    int len;
    logic [2:0] exp_st;
    start = 1'b1;
    tick();
    for (int n = 1; n <= 4; n++) begin
      checks++; if (st !== 3'd1) begin errors++; $display("FAIL retry_detect: got %0d expected 1", st); end
      checks++; if (retry !== 4'(n - 1)) begin errors++; $display("FAIL retry_before: got %0d expected %0d", retry, n - 1); end
      err[0] = 1'b1;
      tick();
      err[0] = 1'b0;
      checks++; if (st !== 3'd4) begin errors++; $display("FAIL retry_drain: got %0d expected 4", st); end
      tick();
      checks++; if (st !== 3'd6) begin errors++; $display("FAIL retry_backoff: got %0d expected 6", st); end
      len = 0;
      while (st == 3'd6 && len < 40) begin len++; tick(); end
      checks++; if (len != 16) begin errors++; $display("FAIL backoff_len: got %0d expected 16", len); end
      checks++; if (retry !== 4'(n)) begin errors++; $display("FAIL retry_count: got %0d expected %0d", retry, n); end
      exp_st = (n == 4) ? 3'd7 : 3'd1;
      checks++; if (st !== exp_st) begin errors++; $display("FAIL retry_next: got %0d expected %0d", st, exp_st); end
    end
    checks++; if (link_fail !== 1'b1 || link_up !== 1'b0) begin errors++; $display("FAIL link_fail: got fail=%b up=%b expected 1/0", link_fail, link_up); end
    repeat (3) tick();
    checks++; if (st !== 3'd7) begin errors++; $display("FAIL fail_hold: got %0d expected 7", st); end
    start = 1'b0;
    tick();
    checks++; if (st !== 3'd0 || retry !== 4'd0 || link_fail !== 1'b0)
      begin errors++; $display("FAIL fail_clear: got state=%0d retry=%0d fail=%b expected 0/0/0", st, retry, link_fail); end
  endtask

  task automatic test_simultaneous();
    go_to_sub(2);
    checks++; if (st !== 3'd3) begin errors++; $display("FAIL simul_config: got %0d expected 3", st); end
    succ[2] = 1'b1; err[2] = 1'b1;
    tick();
    checks++; if (st !== 3'd4) begin errors++; $display("FAIL simul_drain: got %0d expected 4", st); end
    succ[2] = 1'b0; err[2] = 1'b0;
    tick();
    checks++; if (st !== 3'd6 || link_up !== 1'b0) begin errors++; $display("FAIL simul_backoff: got state=%0d up=%b expected 6/0", st, link_up); end
    start = 1'b0;
    tick();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL backoff_abort: got %0d expected 0", st); end
  endtask

  task automatic test_watchdog();
    int n;
    go_to_sub(1);
    checks++; if (st !== 3'd2) begin errors++; $display("FAIL wdog_polling: got %0d expected 2", st); end
    n = 0;
    while (st == 3'd2 && n < 200) begin tick(); n++; end
    checks++; if (n != 100) begin errors++; $display("FAIL wdog_cycles: got %0d expected 100", n); end
    checks++; if (st !== 3'd4) begin errors++; $display("FAIL wdog_drain: got %0d expected 4", st); end
    tick();
    checks++; if (st !== 3'd6) begin errors++; $display("FAIL wdog_backoff: got %0d expected 6", st); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    go_to_sub(1);
    s_valid[1] = 1'b1; s_data[DW +: DW] = 32'hC001; s_last[1] = 1'b0; m_ready = 1'b1;
    #1;
    checks++; if (s_rdy !== 3'b010 || m_data !== 32'hC001) begin errors++; $display("FAIL abort_beat1: got rdy=%b d=%h expected 010/c001", s_rdy, m_data); end
    tick();
    s_data[DW +: DW] = 32'hC002; s_last[1] = 1'b1; m_ready = 1'b0; start = 1'b0;
    tick();
    checks++; if (st !== 3'd4 || m_valid !== 1'b1 || m_data !== 32'hC002 || s_rdy !== 3'b000)
      begin errors++; $display("FAIL abort_open: got state=%0d v=%b d=%h rdy=%b expected 4/1/c002/000", st, m_valid, m_data, s_rdy); end
    m_ready = 1'b1;
    #1;
    checks++; if (m_last !== 1'b1 || s_rdy !== 3'b010) begin errors++; $display("FAIL abort_last: got l=%b rdy=%b expected 1/010", m_last, s_rdy); end
    tick();
    s_data[DW +: DW] = 32'hC003; s_last[1] = 1'b0;
    #1;
    checks++; if (st !== 3'd4 || m_valid !== 1'b0 || s_rdy !== 3'b000)
      begin errors++; $display("FAIL abort_closed: got state=%0d v=%b rdy=%b expected 4/0/000", st, m_valid, s_rdy); end
    tick();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL abort_to_idle: got %0d expected 0", st); end
    s_valid = '0; m_ready = 1'b0;
  endtask

  task automatic test_reset_mid_config();
    go_to_sub(2);
    s_valid[2] = 1'b1; s_data[2*DW +: DW] = 32'hD001; s_last[2] = 1'b0; m_ready = 1'b1;
    tick();
    checks++; if (st !== 3'd3 || m_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: got state=%0d v=%b expected 3/1", st, m_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (st !== 3'd0 || sub_en !== 3'b000 || retry !== 4'd0) begin errors++; $display("FAIL rst_async_state: got state=%0d en=%b retry=%0d expected 0/000/0", st, sub_en, retry); end
    checks++; if (link_up !== 1'b0 || link_fail !== 1'b0) begin errors++; $display("FAIL rst_async_link: got up=%b fail=%b expected 0/0", link_up, link_fail); end
    checks++; if (m_valid !== 1'b0 || s_rdy !== 3'b000 || m_data !== 32'h0) begin errors++; $display("FAIL rst_async_stream: got v=%b rdy=%b d=%h expected 0/000/0", m_valid, s_rdy, m_data); end
    start = 1'b0; s_valid = '0; m_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL rst_release: got %0d expected 0", st); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at 500000, expected to finish earlier");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_happy_path();
    test_ignore_other();
    test_mid_frame();
    test_retry_fail();
    test_simultaneous();
    test_watchdog();
    test_abort();
    test_reset_mid_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
